// File: rtl/alu_nibble_sequencer_if.sv
// Nibble-wide link between alu_nibble_sequencer (master) and an external
// 74181-style slice (slave). Operands flow out and results flow back.
interface alu_nibble_sequencer_if;
  logic [3:0] slice_a;
  logic [3:0] slice_b;
  logic [3:0] slice_s;
  logic       slice_m;
  logic       slice_ci_n;
  logic [3:0] slice_y;
  logic       slice_co_n;
  logic       slice_p;
  logic       slice_q;
  logic       slice_aeqb;

  modport master (
    output slice_a, slice_b, slice_s, slice_m, slice_ci_n,
    input  slice_y, slice_co_n, slice_p, slice_q, slice_aeqb
  );

  modport slave (
    input  slice_a, slice_b, slice_s, slice_m, slice_ci_n,
    output slice_y, slice_co_n, slice_p, slice_q, slice_aeqb
  );
endinterface

// File: rtl/alu_nibble_sequencer.sv
// Runs one W-bit ALU operation through a single 4-bit 74181-style slice, LSB nibble first.
// Optional macro ALU_ZERO_FLAG_EN adds a registered zero-result flag output.
module alu_nibble_sequencer #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [4*NIBBLES-1:0]   a,
  input  logic [4*NIBBLES-1:0]   b,
  input  logic [3:0]             s,
  input  logic                   m,
  input  logic                   ci_n,
  output logic                   busy,
  output logic                   done,
  output logic [4*NIBBLES-1:0]   y,
  output logic                   co_n,
  output logic                   aeqb,
  output logic                   p_n,
  output logic                   g_n,
`ifdef ALU_ZERO_FLAG_EN
  output logic                   zero,
`endif
  alu_nibble_sequencer_if.master slice
);

  localparam int W  = 4 * NIBBLES;
  localparam int KW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t        state_r;
  state_t        state_s;
  logic [KW-1:0] k_r;
  logic [W-1:0]  a_sh_r;
  logic [W-1:0]  b_sh_r;
  logic [W-1:0]  y_r;
  logic [3:0]    s_r;
  logic          m_r;
  logic          cr_r;
  logic          aeqb_acc_r;
  logic          p_acc_r;
  logic          g_acc_r;
  logic          busy_r;
  logic          done_r;
  logic          co_n_r;
  logic          aeqb_r;
  logic          p_n_r;
  logic          g_n_r;
`ifdef ALU_ZERO_FLAG_EN
  logic          z_acc_r;
  logic          zero_r;
`endif

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state decode
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_s = ST_RUN;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (k_r == K_LAST) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_DONE: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // Operand capture, nibble stepping, result assembly and status accumulation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_r        <= '0;
      a_sh_r     <= '0;
      b_sh_r     <= '0;
      y_r        <= '0;
      s_r        <= 4'h0;
      m_r        <= 1'b0;
      cr_r       <= 1'b1;
      aeqb_acc_r <= 1'b1;
      p_acc_r    <= 1'b0;
      g_acc_r    <= 1'b1;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      co_n_r     <= 1'b1;
      aeqb_r     <= 1'b0;
      p_n_r      <= 1'b1;
      g_n_r      <= 1'b1;
`ifdef ALU_ZERO_FLAG_EN
      z_acc_r    <= 1'b1;
      zero_r     <= 1'b0;
`endif
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            a_sh_r     <= a;
            b_sh_r     <= b;
            s_r        <= s;
            m_r        <= m;
            cr_r       <= ci_n;
            k_r        <= '0;
            aeqb_acc_r <= 1'b1;
            p_acc_r    <= 1'b0;
            g_acc_r    <= 1'b1;
            busy_r     <= 1'b1;
`ifdef ALU_ZERO_FLAG_EN
            z_acc_r    <= 1'b1;
`endif
          end
        end
        ST_RUN: begin
          // Operands shift down so the presented nibble always sits in bits [3:0]
          y_r[{k_r, 2'b00} +: 4] <= slice.slice_y;
          a_sh_r     <= a_sh_r >> 4;
          b_sh_r     <= b_sh_r >> 4;
          cr_r       <= slice.slice_co_n;
          aeqb_acc_r <= aeqb_acc_r & slice.slice_aeqb;
          p_acc_r    <= p_acc_r | slice.slice_p;
          g_acc_r    <= slice.slice_q & (slice.slice_p | g_acc_r);
          k_r        <= (k_r == K_LAST) ? '0 : k_r + 1'b1;
`ifdef ALU_ZERO_FLAG_EN
          z_acc_r    <= z_acc_r & (slice.slice_y == 4'h0);
`endif
        end
        ST_DONE: begin
          done_r <= 1'b1;
          busy_r <= 1'b0;
          co_n_r <= cr_r;
          aeqb_r <= aeqb_acc_r;
          p_n_r  <= p_acc_r;
          g_n_r  <= g_acc_r;
`ifdef ALU_ZERO_FLAG_EN
          zero_r <= z_acc_r;
`endif
        end
        default: begin
          done_r <= 1'b0;
          busy_r <= 1'b0;
        end
      endcase
    end
  end

  assign busy             = busy_r;
  assign done             = done_r;
  assign y                = y_r;
  assign co_n             = co_n_r;
  assign aeqb             = aeqb_r;
  assign p_n              = p_n_r;
  assign g_n              = g_n_r;
`ifdef ALU_ZERO_FLAG_EN
  assign zero             = zero_r;
`endif
  assign slice.slice_a    = a_sh_r[3:0];
  assign slice.slice_b    = b_sh_r[3:0];
  assign slice.slice_s    = s_r;
  assign slice.slice_m    = m_r;
  assign slice.slice_ci_n = cr_r;

endmodule

// File: tb/tb_alu_nibble_sequencer.sv
// Self-checking bench: a behavioural 74181 nibble drives the slice link and a
// whole-word arithmetic model supplies the expected results.
module tb_alu_nibble_sequencer;
  localparam int NIBBLES = 4;
  localparam int W       = 4 * NIBBLES;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [W-1:0]  a     = '0;
  logic [W-1:0]  b     = '0;
  logic [3:0]    s     = 4'h0;
  logic          m     = 1'b0;
  logic          ci_n  = 1'b1;
  logic          busy;
  logic          done;
  logic [W-1:0]  y;
  logic          co_n;
  logic          aeqb;
  logic          p_n;
  logic          g_n;
`ifdef ALU_ZERO_FLAG_EN
  logic          zero;
`endif

  int n_checks = 0;
  int n_errors = 0;

  alu_nibble_sequencer_if sif ();

  alu_nibble_sequencer #(.NIBBLES(NIBBLES)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .s     (s),
    .m     (m),
    .ci_n  (ci_n),
    .busy  (busy),
    .done  (done),
    .y     (y),
    .co_n  (co_n),
    .aeqb  (aeqb),
    .p_n   (p_n),
    .g_n   (g_n),
`ifdef ALU_ZERO_FLAG_EN
    .zero  (zero),
`endif
    .slice (sif)
  );

  always #5 clk = ~clk;

  // Behavioural 74181 (active-high data): F = X plus Y plus carry, or XNOR(X,Y) in logic mode
  logic [3:0] sl_x;
  logic [3:0] sl_y;
  logic [4:0] sl_sum;
  logic [4:0] sl_gen;
  logic [3:0] sl_f;
  assign sl_x   = sif.slice_a | (sif.slice_b & {4{sif.slice_s[0]}}) | (~sif.slice_b & {4{sif.slice_s[1]}});
  assign sl_y   = (sif.slice_a & sif.slice_b & {4{sif.slice_s[3]}}) | (sif.slice_a & ~sif.slice_b & {4{sif.slice_s[2]}});
  assign sl_sum = {1'b0, sl_x} + {1'b0, sl_y} + {4'h0, ~sif.slice_ci_n};
  assign sl_gen = {1'b0, sl_x} + {1'b0, sl_y};
  assign sl_f   = sif.slice_m ? ~(sl_x ^ sl_y) : sl_sum[3:0];
  assign sif.slice_y    = sl_f;
  assign sif.slice_co_n = ~sl_sum[4];
  assign sif.slice_p    = ~(&sl_x);
  assign sif.slice_q    = ~sl_gen[4];
  assign sif.slice_aeqb = &sl_f;

  task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Whole-word reference: carry out of X+Y+c over W bits, group status from the same sums
  task automatic ref_op(input logic [W-1:0] ra, input logic [W-1:0] rb, input logic [3:0] rs,
                        input logic rm, input logic rci_n,
                        output logic [W-1:0] ey, output logic eco_n, output logic eaeqb,
                        output logic ep_n, output logic eg_n, output logic ezero);
    logic [W-1:0] x;
    logic [W-1:0] yy;
    logic [W:0]   sum;
    logic [W:0]   gen;
    x     = ra | (rb & {W{rs[0]}}) | (~rb & {W{rs[1]}});
    yy    = (ra & rb & {W{rs[3]}}) | (ra & ~rb & {W{rs[2]}});
    sum   = {1'b0, x} + {1'b0, yy} + {{W{1'b0}}, ~rci_n};
    gen   = {1'b0, x} + {1'b0, yy};
    ey    = rm ? ~(x ^ yy) : sum[W-1:0];
    eco_n = ~sum[W];
    eaeqb = &ey;
    ep_n  = ~(&x);
    eg_n  = ~gen[W];
    ezero = (ey == '0);
  endtask

  task automatic run_op(input logic [W-1:0] ra, input logic [W-1:0] rb, input logic [3:0] rs,
                        input logic rm, input logic rci_n, input bit restart_mid);
    logic [W-1:0] ey;
    logic eco_n, eaeqb, ep_n, eg_n, ezero;
    int lat;
    ref_op(ra, rb, rs, rm, rci_n, ey, eco_n, eaeqb, ep_n, eg_n, ezero);
    @(negedge clk);
    a = ra; b = rb; s = rs; m = rm; ci_n = rci_n; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check_value("busy_after_start", busy, 1'b1);
    lat = 0;
    while (!done && lat < 20) begin
      if (restart_mid && lat == 1) begin
        a = 16'h0001; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1 lat++;
    end
    start = 1'b0;
    check_value("latency", lat, NIBBLES + 1);
    check_value("done", done, 1'b1);
    check_value("busy_at_done", busy, 1'b0);
    check_value("y", y, ey);
    check_value("co_n", co_n, eco_n);
    check_value("aeqb", aeqb, eaeqb);
    check_value("p_n", p_n, ep_n);
    check_value("g_n", g_n, eg_n);
`ifdef ALU_ZERO_FLAG_EN
    check_value("zero", zero, ezero);
`endif
    @(posedge clk);
    #1;
    check_value("done_pulse_ends", done, 1'b0);
    check_value("y_held", y, ey);
  endtask

  task automatic check_reset_values(input string tag);
    check_value({tag, "_busy"}, busy, 1'b0);
    check_value({tag, "_done"}, done, 1'b0);
    check_value({tag, "_y"}, y, 16'h0000);
    check_value({tag, "_co_n"}, co_n, 1'b1);
    check_value({tag, "_aeqb"}, aeqb, 1'b0);
    check_value({tag, "_p_n"}, p_n, 1'b1);
    check_value({tag, "_g_n"}, g_n, 1'b1);
    check_value({tag, "_slice_a"}, sif.slice_a, 4'h0);
    check_value({tag, "_slice_b"}, sif.slice_b, 4'h0);
    check_value({tag, "_slice_ci_n"}, sif.slice_ci_n, 1'b1);
`ifdef ALU_ZERO_FLAG_EN
    check_value({tag, "_zero"}, zero, 1'b0);
`endif
  endtask

  logic [W-1:0] y_first;

  initial begin
    repeat (2) @(posedge clk);
    #1 check_reset_values("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Add without carry
    run_op(16'h1234, 16'h4321, 4'b1001, 1'b0, 1'b1, 1'b0);
    check_value("add_y_const", y, 16'h5555);
    check_value("add_co_n_const", co_n, 1'b1);

    // Add with a carry rippling through every nibble; each nibble of A is F so all propagate
    run_op(16'hFFFF, 16'h0001, 4'b1001, 1'b0, 1'b1, 1'b0);
    check_value("ripple_y_const", y, 16'h0000);
    check_value("ripple_co_n_const", co_n, 1'b0);
    check_value("ripple_p_n_const", p_n, 1'b0);
`ifdef ALU_ZERO_FLAG_EN
    check_value("ripple_zero_const", zero, 1'b1);
`endif

    // Compare via A minus B minus 1
    run_op(16'hABCD, 16'hABCD, 4'b0110, 1'b0, 1'b1, 1'b0);
    check_value("cmp_eq_y_const", y, 16'hFFFF);
    check_value("cmp_eq_aeqb_const", aeqb, 1'b1);
    run_op(16'hABCD, 16'hABCC, 4'b0110, 1'b0, 1'b1, 1'b0);
    check_value("cmp_ne_aeqb_const", aeqb, 1'b0);

    // Logic XOR, insensitive to carry-in
    run_op(16'hF0F0, 16'hFF00, 4'b0110, 1'b1, 1'b0, 1'b0);
    check_value("xor_ci0_y_const", y, 16'h0FF0);
    run_op(16'hF0F0, 16'hFF00, 4'b0110, 1'b1, 1'b1, 1'b0);
    check_value("xor_ci1_y_const", y, 16'h0FF0);

    // A second start two cycles into an operation must be ignored
    run_op(16'h1234, 16'h4321, 4'b1001, 1'b0, 1'b1, 1'b1);
    check_value("ignored_start_y_const", y, 16'h5555);

    // Reset while nibble 2 is on the slice
    @(negedge clk);
    a = 16'h9876; b = 16'h1111; s = 4'b1001; m = 1'b0; ci_n = 1'b1; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_value("nibble2_slice_a", sif.slice_a, 4'h8);
    check_value("nibble2_slice_b", sif.slice_b, 4'h1);
    rst_n = 1'b0;
    #1 check_reset_values("midop_reset");
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1 check_value("no_done_in_reset", done, 1'b0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_op(16'h9876, 16'h1111, 4'b1001, 1'b0, 1'b1, 1'b0);
    check_value("after_reset_y_const", y, 16'hA987);

    // Randomised operations across every function and mode
    for (int i = 0; i < 40; i++) begin
      run_op(W'($urandom), W'($urandom), 4'($urandom), 1'($urandom), 1'($urandom), 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
